// File: rtl/vram_arbiter.sv
// Round-robin arbiter between two engine rmw ports and a single-port synchronous VRAM.
// Writes issue one per cycle; reads block the arbiter until the shared read bus is loaded.
module vram_arbiter #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic                  c0_rts,
    output logic                  c0_rtr,
    input  logic [ADDR_WIDTH-1:0] c0_addr,
    input  logic [DATA_WIDTH-1:0] c0_wdata,
    input  logic [BE_WIDTH-1:0]   c0_wr_op,
    output logic                  c0_bcast_xfc,
    input  logic                  c1_rts,
    output logic                  c1_rtr,
    input  logic [ADDR_WIDTH-1:0] c1_addr,
    input  logic [DATA_WIDTH-1:0] c1_wdata,
    input  logic [BE_WIDTH-1:0]   c1_wr_op,
    output logic                  c1_bcast_xfc,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [BE_WIDTH-1:0]   mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        RD_ISSUE,
        RD_CAPTURE
    } state_t;

    state_t                state, state_nxt;
    logic                  last_grant;
    logic                  rd_owner;
    logic                  grant;
    logic                  xfc;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [BE_WIDTH-1:0]   sel_wr_op;

    // NOTE: every signal gets a default first so no path through the case leaves one unassigned (no latches).
    always_comb begin
        state_nxt = state;
        c0_rtr    = 1'b0;
        c1_rtr    = 1'b0;
        grant     = 1'b0;
        if (c0_rts && c1_rts)
            grant = ~last_grant;
        else if (c1_rts)
            grant = 1'b1;
        sel_addr  = grant ? c1_addr  : c0_addr;
        sel_wdata = grant ? c1_wdata : c0_wdata;
        sel_wr_op = grant ? c1_wr_op : c0_wr_op;
        case (state)
            IDLE: begin
                c0_rtr = c0_rts && !grant;
                c1_rtr = c1_rts && grant;
                if ((c0_rtr || c1_rtr) && (sel_wr_op == '0))
                    state_nxt = RD_ISSUE;
            end
            RD_ISSUE:   state_nxt = RD_CAPTURE;
            RD_CAPTURE: state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
        xfc = c0_rtr || c1_rtr;
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            rd_owner     <= 1'b0;
            mem_en       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_we       <= '0;
            rd_data      <= '0;
            c0_bcast_xfc <= 1'b0;
            c1_bcast_xfc <= 1'b0;
        end else begin
            state <= state_nxt;
            if (xfc) begin
                last_grant <= grant;
                mem_en     <= 1'b1;
                mem_addr   <= sel_addr;
                mem_wdata  <= sel_wdata;
                mem_we     <= sel_wr_op;
                if (sel_wr_op == '0)
                    rd_owner <= grant;
            end else begin
                mem_en <= 1'b0;
                mem_we <= '0;
            end
            // VRAM data is valid during RD_CAPTURE; hand it to the owner as a one-cycle pulse.
            c0_bcast_xfc <= (state == RD_CAPTURE) && !rd_owner;
            c1_bcast_xfc <= (state == RD_CAPTURE) && rd_owner;
            if (state == RD_CAPTURE)
                rd_data <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: behavioural VRAM, shadow memory model and a read-return scoreboard.
module tb_vram_arbiter;

    localparam int AW = 17;
    localparam int DW = 32;
    localparam int BW = 4;

    logic          clk;
    logic          rst_;
    logic          c0_rts, c1_rts;
    logic          c0_rtr, c1_rtr;
    logic [AW-1:0] c0_addr, c1_addr;
    logic [DW-1:0] c0_wdata, c1_wdata;
    logic [BW-1:0] c0_wr_op, c1_wr_op;
    logic          c0_bcast_xfc, c1_bcast_xfc;
    logic [DW-1:0] rd_data;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [BW-1:0] mem_we;
    logic [DW-1:0] mem_rdata;

    vram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) dut (
        .clk(clk), .rst_(rst_),
        .c0_rts(c0_rts), .c0_rtr(c0_rtr), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
        .c0_wr_op(c0_wr_op), .c0_bcast_xfc(c0_bcast_xfc),
        .c1_rts(c1_rts), .c1_rtr(c1_rtr), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
        .c1_wr_op(c1_wr_op), .c1_bcast_xfc(c1_bcast_xfc),
        .rd_data(rd_data), .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (we[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    // Behavioural single-port VRAM with one-cycle read latency.
    logic [31:0] vram    [0:(1<<AW)-1];
    logic [31:0] ref_mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en) begin
            if (mem_we == '0)
                mem_rdata <= vram[mem_addr];
            else
                vram[mem_addr] <= merge(vram[mem_addr], mem_wdata, mem_we);
        end
    end

    typedef struct {
        logic        owner;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic tb_last;

    always @(negedge clk) begin
        if (rst_ && (c0_bcast_xfc || c1_bcast_xfc)) begin
            if (sb.size() == 0) begin
                check("bcast_unexpected", {30'b0, c1_bcast_xfc, c0_bcast_xfc}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("bcast_owner", {30'b0, c1_bcast_xfc, c0_bcast_xfc},
                      mon_e.owner ? 32'd2 : 32'd1);
                check("rd_data", rd_data, mon_e.data);
                check("bcast_latency", cyc, mon_e.cyc);
            end
        end
    end

    // One request from one client; updates the model on the accepting edge.
    task automatic req(input logic cl, input logic [AW-1:0] addr, input logic [31:0] wd,
                       input logic [3:0] we);
        bit granted;
        exp_t e;
        granted = 0;
        if (cl) begin c1_rts = 1; c1_addr = addr; c1_wdata = wd; c1_wr_op = we; end
        else    begin c0_rts = 1; c0_addr = addr; c0_wdata = wd; c0_wr_op = we; end
        for (int k = 0; k < 20 && !granted; k++) begin
            @(negedge clk);
            granted = cl ? c1_rtr : c0_rtr;
        end
        if (!granted) begin
            check("rtr_timeout", 32'd0, 32'd1);
            if (cl) c1_rts = 0; else c0_rts = 0;
            return;
        end
        @(posedge clk);
        #1;
        tb_last = cl;
        if (we != 0) begin
            ref_mem[addr] = merge(ref_mem[addr], wd, we);
        end else begin
            e.owner = cl; e.data = ref_mem[addr]; e.cyc = cyc + 2;
            sb.push_back(e);
        end
        if (cl) c1_rts = 0; else c0_rts = 0;
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
        @(negedge clk);
        check("sb_drain", sb.size(), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            vram[i] = '0;
            ref_mem[i] = '0;
        end
        mem_rdata = '0;
        rst_ = 0; tb_last = 1;
        c0_rts = 0; c0_addr = '0; c0_wdata = '0; c0_wr_op = '0;
        c1_rts = 0; c1_addr = '0; c1_wdata = '0; c1_wr_op = '0;
        #3;
        check("reset_ctrl", {27'b0, c0_rtr, c1_rtr, c0_bcast_xfc, c1_bcast_xfc, mem_en}, 32'd0);
        check("reset_rd_data", rd_data, 32'd0);
        check("reset_mem_addr", {15'b0, mem_addr}, 32'd0);
        @(posedge clk); #1 rst_ = 1;

        // 1: idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_quiet", {27'b0, c0_rtr, c1_rtr, c0_bcast_xfc, c1_bcast_xfc, mem_en}, 32'd0);
        end

        // 2: write then read back on client 0
        @(posedge clk); #1;
        req(0, 17'h00010, 32'hDEADBEEF, 4'hF);
        @(negedge clk);
        check("wr_mem_addr", {15'b0, mem_addr}, 32'h10);
        check("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
        check("wr_mem_we", {28'b0, mem_we}, 32'hF);
        @(posedge clk); #1;
        req(0, 17'h00010, 32'h0, 4'h0);
        drain();

        // 3: both clients stream writes; grants alternate
        @(posedge clk); #1;
        c0_rts = 1; c0_addr = 17'h100; c0_wdata = 32'hC0000000; c0_wr_op = 4'hF;
        c1_rts = 1; c1_addr = 17'h200; c1_wdata = 32'hC1000000; c1_wr_op = 4'hF;
        begin
            logic          exp_g;
            logic [AW-1:0] exp_addr;
            exp_addr = '0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (i > 0) begin
                    check("stream_mem_en", {31'b0, mem_en}, 32'd1);
                    check("stream_mem_addr", {15'b0, mem_addr}, {15'b0, exp_addr});
                end
                exp_g = ~tb_last;
                check("stream_rtr", {30'b0, c1_rtr, c0_rtr}, exp_g ? 32'd2 : 32'd1);
                @(posedge clk); #1;
                tb_last = exp_g;
                if (exp_g) begin
                    exp_addr = c1_addr;
                    ref_mem[c1_addr] = merge(ref_mem[c1_addr], c1_wdata, c1_wr_op);
                    c1_addr = c1_addr + 1; c1_wdata = c1_wdata + 1;
                end else begin
                    exp_addr = c0_addr;
                    ref_mem[c0_addr] = merge(ref_mem[c0_addr], c0_wdata, c0_wr_op);
                    c0_addr = c0_addr + 1; c0_wdata = c0_wdata + 1;
                end
            end
            c0_rts = 0; c1_rts = 0;
            @(negedge clk);
            check("stream_last_en", {31'b0, mem_en}, 32'd1);
            check("stream_last_addr", {15'b0, mem_addr}, {15'b0, exp_addr});
            @(negedge clk);
            check("stream_idle", {27'b0, mem_we, mem_en}, 32'd0);
        end
        @(posedge clk); #1;
        req(1, 17'h201, 32'h0, 4'h0);
        drain();

        // 4: byte-lane merge
        @(posedge clk); #1;
        req(0, 17'h00030, 32'h11223344, 4'hF);
        req(0, 17'h00030, 32'hAABBCCDD, 4'b0101);
        req(1, 17'h00030, 32'h0, 4'h0);
        check("model_byte_merge", ref_mem[17'h30], 32'h11BB33DD);
        drain();

        // 5: client 1 read pending while client 0 holds rts
        @(posedge clk); #1;
        req(1, 17'h00010, 32'h0, 4'h0);
        c0_rts = 1; c0_addr = 17'h00040; c0_wdata = 32'h55AA55AA; c0_wr_op = 4'hF;
        @(negedge clk);
        check("rd_issue_c0_rtr", {31'b0, c0_rtr}, 32'd0);
        @(negedge clk);
        check("rd_capture_c0_rtr", {31'b0, c0_rtr}, 32'd0);
        @(negedge clk);
        check("bcast_cycle_c0_rtr", {30'b0, c1_bcast_xfc, c0_rtr}, 32'd3);
        @(posedge clk); #1;
        ref_mem[17'h40] = merge(ref_mem[17'h40], c0_wdata, c0_wr_op);
        tb_last = 0;
        c0_rts = 0;
        drain();

        // 6: reset while in RD_CAPTURE
        @(posedge clk); #1;
        c0_rts = 1; c0_addr = 17'h00040; c0_wdata = '0; c0_wr_op = '0;
        begin
            bit granted;
            granted = 0;
            for (int k = 0; k < 20 && !granted; k++) begin
                @(negedge clk);
                granted = c0_rtr;
            end
            check("rst_rd_grant", {31'b0, granted}, 32'd1);
        end
        @(posedge clk); #1 c0_rts = 0;
        @(posedge clk); #1 rst_ = 0;
        #1;
        check("midrd_reset_ctrl", {23'b0, mem_we, c0_rtr, c1_rtr, c0_bcast_xfc, c1_bcast_xfc, mem_en},
              32'd0);
        check("midrd_reset_rd_data", rd_data, 32'd0);
        check("midrd_reset_mem_wdata", mem_wdata, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("midrd_no_bcast", {30'b0, c1_bcast_xfc, c0_bcast_xfc}, 32'd0);
        end
        @(posedge clk); #1 rst_ = 1;
        tb_last = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_reset_quiet", {30'b0, c1_bcast_xfc, c0_bcast_xfc}, 32'd0);
        end
        @(posedge clk); #1;
        req(0, 17'h00040, 32'h0, 4'h0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
